// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers,
// with optional inter-byte gap, per-requester burst lock and start timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int GAP_CLKS      = 0,
    parameter int START_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ-1:0]      lock_i,
    input  logic [NUM_REQ-1:0][7:0] data_i,
    output logic [NUM_REQ-1:0]      ack_o,
    output logic [NUM_REQ-1:0]      grant_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic                    tx_start_o,
    output logic [7:0]              tx_data_o,
    input  logic                    tx_busy_i,
    input  logic                    tx_done_i
);
    localparam int IW   = $clog2(NUM_REQ);
    localparam int CW   = IW + 1;
    localparam int MAXC = (GAP_CLKS > START_TIMEOUT) ? GAP_CLKS : START_TIMEOUT;
    localparam int TW   = $clog2(MAXC) + 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CLKS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t        state;
    logic [IW-1:0] last_idx;
    logic [IW-1:0] win_idx;
    logic          win_vld;
    logic [CW-1:0] cand;
    logic [TW-1:0] timer;
    logic          lock_hold;

    assign busy_o = (state != IDLE);

    always_comb begin
        win_vld = 1'b0;
        win_idx = last_idx;
        cand    = '0;
        if (lock_hold && req_i[last_idx]) begin
            win_vld = 1'b1;
        end else begin
            // scan farthest-first so the nearest requester after last_idx wins
            for (int i = NUM_REQ; i >= 1; i--) begin
                cand = CW'(last_idx) + CW'(i);
                if (cand >= CW'(NUM_REQ))
                    cand = cand - CW'(NUM_REQ);
                if (req_i[cand[IW-1:0]]) begin
                    win_vld = 1'b1;
                    win_idx = cand[IW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_idx   <= IW'(NUM_REQ - 1);
            timer      <= '0;
            lock_hold  <= 1'b0;
            ack_o      <= '0;
            grant_o    <= '0;
            err_o      <= 1'b0;
            tx_start_o <= 1'b0;
            tx_data_o  <= '0;
        end else begin
            tx_start_o <= 1'b0;
            ack_o      <= '0;
            err_o      <= 1'b0;
            case (state)
                IDLE: begin
                    // a locked requester that drops its request gives up the lock
                    if (lock_hold && !req_i[last_idx])
                        lock_hold <= 1'b0;
                    if (win_vld) begin
                        tx_data_o         <= data_i[win_idx];
                        tx_start_o        <= 1'b1;
                        ack_o[win_idx]    <= 1'b1;
                        grant_o           <= '0;
                        grant_o[win_idx]  <= 1'b1;
                        last_idx          <= win_idx;
                        timer             <= '0;
                        lock_hold         <= 1'b0;
                        state             <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY, WAIT_DONE: begin
                    if (tx_done_i) begin
                        lock_hold <= lock_i[last_idx];
                        timer     <= '0;
                        if (GAP_CLKS > 0) begin
                            state <= GAP;
                        end else begin
                            grant_o <= '0;
                            state   <= IDLE;
                        end
                    end else if (state == WAIT_BUSY) begin
                        if (tx_busy_i) begin
                            state <= WAIT_DONE;
                        end else if (timer == TO_LAST) begin
                            err_o     <= 1'b1;
                            grant_o   <= '0;
                            lock_hold <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (timer == GAP_LAST) begin
                        grant_o <= '0;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester and transmitter models plus an expected-byte queue.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ       = 4;
    localparam int GAP_CLKS      = 3;
    localparam int START_TIMEOUT = 16;
    localparam int BOUND         = 300;

    typedef struct {
        logic [7:0] data;
        int         idx;
    } exp_t;

    logic                    clk       = 1'b0;
    logic                    reset     = 1'b1;
    logic [NUM_REQ-1:0]      req_i     = '0;
    logic [NUM_REQ-1:0]      lock_i    = '0;
    logic [NUM_REQ-1:0][7:0] data_i    = '0;
    logic                    tx_busy_i = 1'b0;
    logic                    tx_done_i = 1'b0;
    logic [NUM_REQ-1:0]      ack_o;
    logic [NUM_REQ-1:0]      grant_o;
    logic                    busy_o;
    logic                    err_o;
    logic                    tx_start_o;
    logic [7:0]              tx_data_o;

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [7:0] src_mem[NUM_REQ][16];
    int         src_n[NUM_REQ] = '{default: 0};
    int         src_p[NUM_REQ] = '{default: 0};
    int         launch_cnt  = 0;
    int         launch_seen = 0;
    bit         tx_silent   = 1'b0;
    int         tx_len      = 4;
    int         tx_cnt      = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .GAP_CLKS     (GAP_CLKS),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .lock_i    (lock_i),
        .data_i    (data_i),
        .ack_o     (ack_o),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .err_o     (err_o),
        .tx_start_o(tx_start_o),
        .tx_data_o (tx_data_o),
        .tx_busy_i (tx_busy_i),
        .tx_done_i (tx_done_i)
    );

    always #5 clk = ~clk;

    // Requesters: present the next queued byte after each ack, else drop req.
    always @(negedge clk) begin
        if (reset) begin
            req_i = '0;
            for (int k = 0; k < NUM_REQ; k++) src_p[k] = src_n[k];
            launch_seen = launch_cnt;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (ack_o[k]) begin
                    if (src_p[k] < src_n[k]) begin
                        data_i[k] = src_mem[k][src_p[k]];
                        src_p[k]++;
                    end else begin
                        req_i[k] = 1'b0;
                    end
                end
            end
            if (launch_cnt != launch_seen) begin
                launch_seen = launch_cnt;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (!req_i[k] && src_p[k] < src_n[k]) begin
                        data_i[k] = src_mem[k][src_p[k]];
                        src_p[k]++;
                        req_i[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Transmitter: busy one clock after it sees start, done pulse after tx_len busy clocks.
    always @(negedge clk) begin
        if (reset) begin
            tx_cnt    = 0;
            tx_busy_i = 1'b0;
            tx_done_i = 1'b0;
        end else begin
            tx_done_i = 1'b0;
            if (tx_start_o && !tx_silent) begin
                tx_cnt = 1;
            end else if (tx_cnt != 0) begin
                tx_cnt++;
                if (tx_cnt == tx_len + 2) begin
                    tx_cnt    = 0;
                    tx_busy_i = 1'b0;
                    tx_done_i = 1'b1;
                end else begin
                    tx_busy_i = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [7:0] b);
        src_mem[k][src_n[k]] = b;
        src_n[k]++;
    endtask

    task automatic expect_byte(input int k, input logic [7:0] b);
        exp_q.push_back('{data: b, idx: k});
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < BOUND && !ok; n++) begin
            tick();
            if (tx_start_o) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_start: no tx_start_o within %0d clks", BOUND);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < BOUND && !ok; n++) begin
            tick();
            if (tx_done_i) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_done: no tx_done_i within %0d clks", BOUND);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < BOUND && !ok; n++) begin
            tick();
            if (!busy_o && req_i == '0) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy_o=%b req_i=%b after %0d clks", busy_o, req_i, BOUND);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (ack_o !== '0 || grant_o !== '0 || busy_o !== 1'b0 || err_o !== 1'b0 ||
            tx_start_o !== 1'b0 || tx_data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: ack=%b grant=%b busy=%b err=%b start=%b data=%h, want all 0",
                     ack_o, grant_o, busy_o, err_o, tx_start_o, tx_data_o);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || grant_o !== '0) begin
            errors++;
            $display("FAIL reset_release: busy=%b grant=%b, want 0/0000", busy_o, grant_o);
        end
    endtask

    task automatic test_contention();
        bit ok; exp_t e; logic [NUM_REQ-1:0] oh;
        load(0, 8'h11); load(1, 8'h22); load(2, 8'h33); load(3, 8'h44); load(0, 8'h11);
        expect_byte(0, 8'h11); expect_byte(1, 8'h22); expect_byte(2, 8'h33);
        expect_byte(3, 8'h44); expect_byte(0, 8'h11);
        launch_cnt++;
        for (int s = 0; s < 5; s++) begin
            wait_start(ok);
            if (ok && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                oh = NUM_REQ'(1) << e.idx;
                checks++;
                if (tx_data_o !== e.data || ack_o !== oh || grant_o !== oh) begin
                    errors++;
                    $display("FAIL contention[%0d]: data=%h ack=%b grant=%b, want data=%h ack/grant=%b",
                             s, tx_data_o, ack_o, grant_o, e.data, oh);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_single();
        bit ok; exp_t e;
        tx_len = 40;
        load(2, 8'hA5); expect_byte(2, 8'hA5);
        launch_cnt++;
        wait_start(ok);
        if (ok && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (tx_data_o !== e.data || ack_o !== 4'b0100 || grant_o !== 4'b0100 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL single_capture: data=%h ack=%b grant=%b busy=%b, want A5/0100/0100/1",
                         tx_data_o, ack_o, grant_o, busy_o);
            end
        end
        tick();
        checks++;
        if (tx_start_o !== 1'b0 || ack_o !== '0 || tx_data_o !== 8'hA5 || grant_o !== 4'b0100) begin
            errors++;
            $display("FAIL single_pulse: start=%b ack=%b data=%h grant=%b, want 0/0000/A5/0100",
                     tx_start_o, ack_o, tx_data_o, grant_o);
        end
        wait_done(ok);
        if (ok) begin
            checks++;
            if (grant_o !== 4'b0100 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL single_hold: grant=%b busy=%b at done, want 0100/1", grant_o, busy_o);
            end
            // done sampled at edge D; GAP spans edges D..D+2, IDLE from D+3
            tick(); tick(); tick();
            checks++;
            if (grant_o !== 4'b0100 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL single_gap: grant=%b busy=%b in gap, want 0100/1", grant_o, busy_o);
            end
            tick();
            checks++;
            if (grant_o !== '0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL single_release: grant=%b busy=%b after gap, want 0000/0", grant_o, busy_o);
            end
        end
        tx_len = 4;
        wait_idle();
    endtask

    task automatic test_rr_wrap();
        bit ok; exp_t e; logic [NUM_REQ-1:0] oh;
        load(3, 8'h3C); expect_byte(3, 8'h3C);
        launch_cnt++;
        for (int s = 0; s < 3; s++) begin
            if (s == 1) begin
                wait_idle();
                load(0, 8'h0A); load(3, 8'h3B);
                expect_byte(0, 8'h0A); expect_byte(3, 8'h3B);
                launch_cnt++;
            end
            wait_start(ok);
            if (ok && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                oh = NUM_REQ'(1) << e.idx;
                checks++;
                if (tx_data_o !== e.data || ack_o !== oh || grant_o !== oh) begin
                    errors++;
                    $display("FAIL rr_wrap[%0d]: data=%h ack=%b grant=%b, want data=%h ack/grant=%b",
                             s, tx_data_o, ack_o, grant_o, e.data, oh);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_lock_burst();
        bit ok; exp_t e; logic [NUM_REQ-1:0] oh;
        load(0, 8'h01); expect_byte(0, 8'h01);
        launch_cnt++;
        for (int s = 0; s < 5; s++) begin
            if (s == 1) begin
                wait_idle();
                lock_i = 4'b0010;
                load(1, 8'hB1); load(1, 8'hB2); load(1, 8'hB3); load(0, 8'hC0);
                expect_byte(1, 8'hB1); expect_byte(1, 8'hB2); expect_byte(1, 8'hB3);
                expect_byte(0, 8'hC0);
                launch_cnt++;
            end
            wait_start(ok);
            if (ok && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                oh = NUM_REQ'(1) << e.idx;
                checks++;
                if (tx_data_o !== e.data || ack_o !== oh || grant_o !== oh) begin
                    errors++;
                    $display("FAIL lock_burst[%0d]: data=%h ack=%b grant=%b, want data=%h ack/grant=%b",
                             s, tx_data_o, ack_o, grant_o, e.data, oh);
                end
            end
        end
        wait_idle();
        lock_i = '0;
    endtask

    task automatic test_timeout();
        bit ok; exp_t e; int n;
        tx_silent = 1'b1;
        load(2, 8'hEE); expect_byte(2, 8'hEE);
        launch_cnt++;
        wait_start(ok);
        if (ok && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (tx_data_o !== e.data || grant_o !== 4'b0100) begin
                errors++;
                $display("FAIL timeout_capture: data=%h grant=%b, want %h/0100", tx_data_o, grant_o, e.data);
            end
        end
        n = 0;
        while (n < 3 * START_TIMEOUT) begin
            tick();
            n++;
            if (err_o) break;
        end
        checks++;
        if (n != START_TIMEOUT) begin
            errors++;
            $display("FAIL timeout_latency: err_o after %0d clks, want %0d", n, START_TIMEOUT);
        end
        checks++;
        if (grant_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: grant=%b busy=%b, want 0000/0", grant_o, busy_o);
        end
        tick();
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: err_o=%b one clk later, want 0", err_o);
        end
        tx_silent = 1'b0;
        load(1, 8'h77); expect_byte(1, 8'h77);
        launch_cnt++;
        wait_start(ok);
        if (ok && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (tx_data_o !== e.data || ack_o !== 4'b0010 || grant_o !== 4'b0010) begin
                errors++;
                $display("FAIL timeout_recover: data=%h ack=%b grant=%b, want %h/0010/0010",
                         tx_data_o, ack_o, grant_o, e.data);
            end
        end
        wait_idle();
    endtask

    task automatic test_gap_reset();
        bit ok; exp_t e; int n; logic [NUM_REQ-1:0] oh;
        load(1, 8'hD1); load(1, 8'hD2);
        expect_byte(1, 8'hD1); expect_byte(1, 8'hD2);
        launch_cnt++;
        wait_start(ok);
        if (ok && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (tx_data_o !== e.data || grant_o !== 4'b0010) begin
                errors++;
                $display("FAIL gap_first: data=%h grant=%b, want %h/0010", tx_data_o, grant_o, e.data);
            end
        end
        wait_done(ok);
        @(posedge clk);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (tx_start_o) break;
        end
        checks++;
        if (n != GAP_CLKS + 1) begin
            errors++;
            $display("FAIL gap_latency: start %0d clks after done edge, want %0d", n, GAP_CLKS + 1);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (tx_data_o !== e.data || grant_o !== 4'b0010) begin
                errors++;
                $display("FAIL gap_second: data=%h grant=%b, want %h/0010", tx_data_o, grant_o, e.data);
            end
        end
        n = 0;
        while (n < 20 && !tx_busy_i) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (busy_o !== 1'b1 || grant_o !== 4'b0010 || tx_data_o !== 8'hD2) begin
            errors++;
            $display("FAIL gap_pre_reset: busy=%b grant=%b data=%h, want 1/0010/D2", busy_o, grant_o, tx_data_o);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ack_o !== '0 || grant_o !== '0 || busy_o !== 1'b0 || err_o !== 1'b0 ||
            tx_start_o !== 1'b0 || tx_data_o !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: ack=%b grant=%b busy=%b err=%b start=%b data=%h, want all 0",
                     ack_o, grant_o, busy_o, err_o, tx_start_o, tx_data_o);
        end
        exp_q.delete();
        tick(); tick();
        reset = 1'b0;
        // last served before reset was 1; requester 0 must still come first
        load(0, 8'h50); load(2, 8'h52);
        expect_byte(0, 8'h50); expect_byte(2, 8'h52);
        launch_cnt++;
        for (int s = 0; s < 2; s++) begin
            wait_start(ok);
            if (ok && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                oh = NUM_REQ'(1) << e.idx;
                checks++;
                if (tx_data_o !== e.data || ack_o !== oh || grant_o !== oh) begin
                    errors++;
                    $display("FAIL reset_priority[%0d]: data=%h ack=%b grant=%b, want data=%h ack/grant=%b",
                             s, tx_data_o, ack_o, grant_o, e.data, oh);
                end
            end
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_rr_wrap();
        test_lock_burst();
        test_timeout();
        test_gap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
- Each requester presents a byte and a request. The arbiter picks a winner, loads the byte into the transmitter, and tracks it through busy/done.
- Enforces an optional inter-byte gap and supports per-requester lock for multi-byte bursts.
- Sits between client logic (status reporter, debug dump, command responder) and the single uart_tx instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CLKS, 0, idle clocks inserted after each tx_done_i before the next arbitration.
- START_TIMEOUT, 16, clocks allowed after tx_start_o for tx_busy_i or tx_done_i to assert before abort.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester request; held high until its ack_o bit pulses.
- lock_i  input  NUM_REQ  per-requester burst lock; sampled at tx_done_i of that requester's byte.
- data_i  input  8*NUM_REQ  requester k's byte on bits [8k+7:8k].
- ack_o  output  NUM_REQ  one-cycle pulse: byte of requester k captured.
- grant_o  output  NUM_REQ  one-hot owner of the transmitter, held from capture until the end of GAP.
- busy_o  output  1  high in every state except IDLE.
- err_o  output  1  one-cycle pulse on start timeout.
- tx_start_o  output  1  one-cycle start pulse to the transmitter.
- tx_data_o  output  8  byte to the transmitter, stable from the start pulse until the next capture.
- tx_busy_i  input  1  transmitter busy.
- tx_done_i  input  1  transmitter single-cycle done pulse.

Behaviour:
- Reset (asynchronous, any state):
  - All outputs go to 0 and state goes to IDLE.
  - last_idx resets to NUM_REQ-1, so requester 0 has first priority.
  - timer resets to 0; lock_hold resets to 0.
- State IDLE:
  - If lock_hold=1 and req_i[last_idx]=1, the winner is last_idx.
  - Otherwise the winner is the first set req_i bit searching from last_idx+1 upward, with modulo NUM_REQ wrap.
  - No request: stay in IDLE, outputs 0.
  - On a winner w, in one registered cycle:
    - tx_data_o<=data_i[w], tx_start_o<=1, ack_o[w]<=1, grant_o<=onehot(w);
    - last_idx<=w, timer<=0, lock_hold<=0, state<=WAIT_BUSY.
  - Capture-to-start latency is 0: start and ack appear on the same edge, one clock after req is sampled.
- State WAIT_BUSY:
  - tx_start_o and ack_o return to 0 on the next clock.
  - If tx_done_i=1: go to post-byte handling (see WAIT_DONE).
  - Else if tx_busy_i=1: go to WAIT_DONE.
  - Else if timer=START_TIMEOUT-1: err_o<=1 for one cycle, grant_o<=0, lock_hold<=0, state<=IDLE. The byte is dropped; no retry.
  - Else timer increments.
- State WAIT_DONE:
  - Waits for tx_done_i.
  - On tx_done_i: lock_hold<=lock_i[last_idx], timer<=0.
  - Then state<=GAP if GAP_CLKS>0, else IDLE with grant_o<=0.
- State GAP:
  - timer counts 0..GAP_CLKS-1, then grant_o<=0 and state<=IDLE.
  - New requests are ignored during GAP.
- Simultaneous events:
  - tx_busy_i and tx_done_i together in WAIT_BUSY: done takes precedence.
  - req_i changes after capture have no effect on the current byte.
  - A requester deasserting req while lock_hold=1 releases the lock: normal round-robin applies.
- Requester rules:
  - A requester whose ack has pulsed must present its next byte or drop req in the cycle after ack.
  - If req stays high, it is treated as a new byte request.
- Fairness: without locks, every continuously requesting requester is served within NUM_REQ bytes.
- Counters: timer is $clog2(max(GAP_CLKS,START_TIMEOUT))+1 bits wide; no wrap is possible.
- grant_o is never non-zero in IDLE.

Test Plan:
- Single requester: req_i=4'b0100, data 8'hA5; tx_busy_i 2 clks after start, tx_done_i 40 clks later.
  -> ack_o[2] and tx_start_o pulse together, tx_data_o=A5, grant_o=0100 until done, busy_o then 0.
- Contention: req_i=1111 held, bytes 11/22/33/44.
  -> tx_data_o sequence 11,22,33,44,11; each ack pulse one-hot.
- Round-robin wrap: last served is 3, then req_i=1001.
  -> requester 0 served, then 3.
- Lock burst: req_i=0011, lock_i[1]=1 for 3 bytes, requester 1 served first.
  -> three consecutive bytes from requester 1, then requester 0.
- Timeout: START_TIMEOUT=16, tx_busy_i/tx_done_i held 0 after start.
  -> err_o pulses exactly 16 clks after tx_start_o, grant_o=0, IDLE, next request served normally.
- GAP_CLKS=3 and mid-transaction reset:
  - next tx_start_o comes 4 clks after tx_done_i;
  - reset asserted in WAIT_DONE clears all outputs asynchronously (before the next clk edge);
  - after release, requester 0 has priority.
